// File: rtl/load_align_pkg.sv
// Shared types and helpers for the load alignment unit.
// Build option: MISALIGNED_LOAD_EN adds the two-word (REQ1/WAIT1) states.
package load_align_pkg;

   typedef enum logic [2:0] {
      LSEL_NONE  = 3'b000,
      LSEL_LH    = 3'b001,
      LSEL_LW    = 3'b010,
      LSEL_LB    = 3'b011,
      LSEL_LBU   = 3'b100,
      LSEL_LHU   = 3'b101,
      LSEL_LUI   = 3'b110,
      LSEL_AUIPC = 3'b111
   } lsel_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ0  = 3'd1,
      S_WAIT0 = 3'd2,
      S_DONE  = 3'd5
`ifdef MISALIGNED_LOAD_EN
      , S_REQ1  = 3'd3,
      S_WAIT1 = 3'd4
`endif
   } state_e;

   function automatic logic is_load(lsel_e op);
      return op inside {LSEL_LB, LSEL_LBU, LSEL_LH, LSEL_LHU, LSEL_LW};
   endfunction

   // True when the access touches bytes in the following word
   function automatic logic spans(lsel_e op, logic [1:0] off);
      case (op)
         LSEL_LH, LSEL_LHU: return off == 2'd3;
         LSEL_LW:           return off != 2'd0;
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_extract.sv
// Byte selection and sign/zero extension for loaded data.
module load_extract
   import load_align_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  off,
   input  logic [63:0] words,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // Drop the bytes below the load address, then size and extend the result
   always_comb begin
      shifted = 32'(words >> {off, 3'b000});
      case (lsel_e'(op))
         LSEL_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
         LSEL_LBU: data = {24'h000000, shifted[7:0]};
         LSEL_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
         LSEL_LHU: data = {16'h0000, shifted[15:0]};
         LSEL_LW:  data = shifted;
         default:  data = '0;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two word reads and aligns the result.
// Build option: MISALIGNED_LOAD_EN enables two-beat loads for accesses that
// cross a word boundary; without it such loads return an error immediately.
module load_align_unit
   import load_align_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        lsel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       immediate,
   input  logic [31:0]       pc,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef MISALIGNED_LOAD_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   state_e           state;
   lsel_e            op_q;
   logic [1:0]       off_q;
   logic [31:0]      word0_q;
`ifdef MISALIGNED_LOAD_EN
   logic [31:0]      word1_q;
`endif
   logic [CNT_W-1:0] cnt;

   lsel_e            op_in;
   logic [31:0]      direct_data;
   logic [31:0]      load_data;
   logic [63:0]      words;
   logic             timed_out;

   assign op_in     = lsel_e'(lsel);
   assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

   // Feed the extractor the beat arriving this cycle so the result registers on entry to DONE
   always_comb begin
      words[31:0] = (state == S_WAIT0) ? mem_rdata : word0_q;
`ifdef MISALIGNED_LOAD_EN
      words[63:32] = (state == S_WAIT1) ? mem_rdata : word1_q;
`else
      words[63:32] = '0;
`endif
   end

   // Results of the operations that need no memory access
   always_comb begin
      direct_data = '0;
      if (op_in == LSEL_LUI)
         direct_data = immediate;
      else if (op_in == LSEL_AUIPC)
         direct_data = immediate + pc;
   end

   load_extract u_extract (
      .op    (op_q),
      .off   (off_q),
      .words (words),
      .data  (load_data)
   );

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         op_q       <= LSEL_NONE;
         off_q      <= '0;
         word0_q    <= '0;
`ifdef MISALIGNED_LOAD_EN
         word1_q    <= '0;
`endif
         cnt        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q      <= op_in;
                  off_q     <= addr[1:0];
                  req_ready <= 1'b0;
                  cnt       <= '0;
                  if (!is_load(op_in)) begin
                     state      <= S_DONE;
                     resp_valid <= 1'b1;
                     resp_data  <= direct_data;
                  end else if (!SPLIT_EN && spans(op_in, addr[1:0])) begin
                     state      <= S_DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state    <= S_REQ0;
                     mem_req  <= 1'b1;
                     mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            S_REQ0: begin
               mem_req <= 1'b0;
               state   <= S_WAIT0;
            end
            S_WAIT0: begin
               if (mem_rvalid) begin
                  word0_q <= mem_rdata;
                  cnt     <= '0;
`ifdef MISALIGNED_LOAD_EN
                  if (spans(op_q, off_q)) begin
                     state    <= S_REQ1;
                     mem_req  <= 1'b1;
                     mem_addr <= mem_addr + ADDR_W'(4);
                  end else
`endif
                  begin
                     state      <= S_DONE;
                     resp_valid <= 1'b1;
                     resp_data  <= load_data;
                  end
               end else if (timed_out) begin
                  state      <= S_DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef MISALIGNED_LOAD_EN
            S_REQ1: begin
               mem_req <= 1'b0;
               state   <= S_WAIT1;
            end
            S_WAIT1: begin
               if (mem_rvalid) begin
                  word1_q    <= mem_rdata;
                  state      <= S_DONE;
                  resp_valid <= 1'b1;
                  resp_data  <= load_data;
               end else if (timed_out) begin
                  state      <= S_DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            S_DONE: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_data  <= '0;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit with a byte-level reference model.
// Follows the MISALIGNED_LOAD_EN setting of the design build.
module tb_load_align_unit;

   localparam int TMO = 4;
`ifdef MISALIGNED_LOAD_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   localparam logic [2:0] OP_NONE = 3'b000, OP_LH = 3'b001, OP_LW = 3'b010, OP_LB = 3'b011,
                          OP_LBU = 3'b100, OP_LHU = 3'b101, OP_LUI = 3'b110, OP_AUIPC = 3'b111;

   logic        clk, rst, req_valid, req_ready;
   logic [2:0]  lsel;
   logic [31:0] addr, immediate, pc;
   logic        resp_valid, resp_err, mem_req, mem_rvalid;
   logic [31:0] resp_data, mem_addr, mem_rdata;

   load_align_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .lsel(lsel), .addr(addr), .immediate(immediate), .pc(pc),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int unsigned lat;
      int unsigned acc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];
   int          dly_q[$];
   logic [31:0] mem_ovr[logic [31:0]];

   int          total = 0;
   int          bad = 0;
   int unsigned cyc = 0;
   bit          pend = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end, want finish");
      $fatal(1, "watchdog");
   end

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_word(logic [31:0] w);
      if (mem_ovr.exists(w)) return mem_ovr[w];
      return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [7:0] byte_at(logic [31:0] a);
      logic [31:0] t;
      t = mem_word({a[31:2], 2'b00}) >> (8 * a[1:0]);
      return t[7:0];
   endfunction

   // Reference: assemble bytes one by one; queue the expected memory beats
   task automatic predict(input logic [2:0] op, input logic [31:0] a, imm, pcv,
                          input int d0, d1,
                          output logic [31:0] data, output logic err, output int unsigned lat);
      int n;
      bit sgn;
      int beats;
      int d;
      logic [31:0] v;
      data = '0; err = 1'b0; lat = 1; n = 0; sgn = 1'b0;
      case (op)
         OP_LUI:   data = imm;
         OP_AUIPC: data = imm + pcv;
         OP_LB:    begin n = 1; sgn = 1'b1; end
         OP_LBU:   n = 1;
         OP_LH:    begin n = 2; sgn = 1'b1; end
         OP_LHU:   n = 2;
         OP_LW:    n = 4;
         default:  n = 0;
      endcase
      if (n == 0) return;
      beats = (int'(a[1:0]) + n > 4) ? 2 : 1;
      if (beats == 2 && !SPLIT) begin
         err = 1'b1;
         return;
      end
      for (int b = 0; b < beats; b++) begin
         d = (b == 0) ? d0 : d1;
         addr_q.push_back({a[31:2], 2'b00} + 32'(4 * b));
         dly_q.push_back(d);
         if (d > TMO) begin
            lat += 1 + TMO;
            err = 1'b1;
            break;
         end
         lat += 1 + d;
      end
      if (err) return;
      v = '0;
      for (int i = 0; i < n; i++) v |= 32'(byte_at(a + 32'(i))) << (8 * i);
      if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
      data = v;
   endtask

   // Memory model: checks request addresses and answers after the chosen delay
   initial begin
      int rem;
      logic [31:0] pdata;
      mem_rvalid = 0;
      mem_rdata = '0;
      rem = 0;
      pdata = '0;
      forever begin
         @(negedge clk);
         mem_rvalid = 0;
         mem_rdata = $urandom;
         if (pend) begin
            rem--;
            if (rem <= 0) begin
               mem_rvalid = 1;
               mem_rdata = pdata;
               pend = 0;
            end
         end
         if (mem_req) begin
            if (addr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_mem_req: got addr %h want no request", mem_addr);
               rem = 1;
            end else begin
               check("mem_addr", mem_addr, addr_q.pop_front());
               rem = dly_q.pop_front();
            end
            pdata = mem_word(mem_addr);
            pend = 1;
         end
      end
   end

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_resp: got data %h err %b want no response", resp_data, resp_err);
            end else begin
               e = exp_q.pop_front();
               check("resp_data", resp_data, e.data);
               check("resp_err", resp_err, e.err);
               check("latency", cyc - e.acc, e.lat);
            end
         end else begin
            check("idle_data_zero", resp_data, '0);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, imm, pcv,
                        input int d0, d1, input bit abort,
                        input bit fx, input logic [31:0] fdata, input logic ferr);
      exp_t e;
      int k;
      k = 0;
      while (!req_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("req_ready_before", req_ready, 1'b1);
      predict(op, a, imm, pcv, d0, d1, e.data, e.err, e.lat);
      if (fx) begin
         e.data = fdata;
         e.err = ferr;
      end
      e.acc = cyc;
      if (!abort) exp_q.push_back(e);
      req_valid = 1; lsel = op; addr = a; immediate = imm; pc = pcv;
      @(posedge clk);
      #1;
      req_valid = 0; lsel = 3'($urandom); addr = $urandom; immediate = $urandom; pc = $urandom;
      if (abort) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!mem_req && k < 20);
         check("abort_mem_req", mem_req, 1'b1);
         @(negedge clk);
         rst = 1;
         @(negedge clk);
         check("rst_resp_valid", resp_valid, 1'b0);
         check("rst_mem_req", mem_req, 1'b0);
         check("rst_mem_addr", mem_addr, '0);
         check("rst_req_ready", req_ready, 1'b1);
         rst = 0;
      end
      for (k = 0; k < 400; k++) begin
         if (exp_q.size() == 0 && !pend) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0 || pend) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d pending responses want 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      check("unused_mem_beats", addr_q.size(), 0);
      addr_q.delete();
      dly_q.delete();
      check("req_ready_after", req_ready, 1'b1);
   endtask

   initial begin
      logic [2:0] op;
      logic [31:0] a;
      int d0, d1;
      rst = 1; req_valid = 0; lsel = '0; addr = '0; immediate = '0; pc = '0;
      @(negedge clk);
      check("reset_req_ready", req_ready, 1'b1);
      check("reset_resp_valid", resp_valid, 1'b0);
      check("reset_resp_data", resp_data, '0);
      check("reset_resp_err", resp_err, 1'b0);
      check("reset_mem_req", mem_req, 1'b0);
      check("reset_mem_addr", mem_addr, '0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      issue(OP_LUI, 32'h0, 32'h12345000, 32'h0, 1, 1, 0, 1, 32'h12345000, 1'b0);
      issue(OP_AUIPC, 32'h0, 32'h12345000, 32'h100, 1, 1, 0, 1, 32'h12345100, 1'b0);
      issue(OP_NONE, 32'h5, 32'hFFFF0000, 32'h44, 1, 1, 0, 1, 32'h0, 1'b0);

      mem_ovr[32'h1000] = 32'h80FF7F01;
      issue(OP_LB, 32'h1002, 32'h0, 32'h0, 1, 1, 0, 1, 32'hFFFFFFFF, 1'b0);
      issue(OP_LBU, 32'h1002, 32'h0, 32'h0, 1, 1, 0, 1, 32'h000000FF, 1'b0);
      issue(OP_LH, 32'h1000, 32'h0, 32'h0, 2, 1, 0, 1, 32'h00007F01, 1'b0);

      mem_ovr[32'h1000] = 32'hAABBCCDD;
      mem_ovr[32'h1004] = 32'h11223344;
      if (SPLIT) issue(OP_LW, 32'h1003, 32'h0, 32'h0, 1, 1, 0, 1, 32'h223344AA, 1'b0);
      else       issue(OP_LW, 32'h1003, 32'h0, 32'h0, 1, 1, 0, 1, 32'h0, 1'b1);

      issue(OP_LH, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 2, 0, 0, 32'h0, 1'b0);
      issue(OP_LHU, 32'hFFFFFFFE, 32'h0, 32'h0, 3, 1, 0, 0, 32'h0, 1'b0);

      issue(OP_LW, 32'h2000, 32'h0, 32'h0, TMO, 1, 0, 0, 32'h0, 1'b0);
      issue(OP_LW, 32'h2000, 32'h0, 32'h0, TMO + 1, 1, 0, 1, 32'h0, 1'b1);
      issue(OP_LW, 32'h2004, 32'h0, 32'h0, TMO + 2, 1, 0, 1, 32'h0, 1'b1);
      issue(OP_LW, 32'h2001, 32'h0, 32'h0, 2, TMO + 1, 0, 0, 32'h0, 1'b0);
      issue(OP_LW, 32'h2002, 32'h0, 32'h0, 1, TMO, 0, 0, 32'h0, 1'b0);

      mem_ovr[32'h3000] = 32'hCAFEF00D;
      issue(OP_LW, 32'h3000, 32'h0, 32'h0, 3, 1, 1, 0, 32'h0, 1'b0);
      issue(OP_LW, 32'h3000, 32'h0, 32'h0, 2, 1, 0, 1, 32'hCAFEF00D, 1'b0);

      for (int t = 0; t < 60; t++) begin
         op = 3'($urandom_range(0, 7));
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
         d0 = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(1, 2) : $urandom_range(1, TMO);
         d1 = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(1, 2) : $urandom_range(1, TMO);
         issue(op, a, $urandom, $urandom, d0, d1, 0, 0, 32'h0, 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
